// File: rtl/debug_trigger_controller_pkg.sv
// Shared types and defaults for the debug trigger/freeze sequencer.
package DebugTriggerTypes;

    localparam int PC_WIDTH_DEF   = 32;
    localparam int PASS_WIDTH_DEF = 8;
    localparam int POST_WIDTH_DEF = 8;
    localparam int SNAP_WORDS_DEF = 16;
    localparam int WORD_WIDTH_DEF = 32;

    // A one-word snapshot still needs a 1-bit index register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int IDX_WIDTH_DEF = idx_width(SNAP_WORDS_DEF);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        POST   = 3'd2,
        FROZEN = 3'd3,
        DUMP   = 3'd4
    } DebugTriggerState;

    typedef logic [PC_WIDTH_DEF-1:0]   pc_t;
    typedef logic [PASS_WIDTH_DEF-1:0] pass_t;
    typedef logic [POST_WIDTH_DEF-1:0] post_t;
    typedef logic [IDX_WIDTH_DEF-1:0]  idx_t;

endpackage

// File: rtl/debug_trigger_controller_if.sv
// Snapshot output stream: valid/ready handshake carrying one word per beat.
import DebugTriggerTypes::*;

interface debug_trigger_controller_if #(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF
);
    logic                  outValid;
    logic                  outReady;
    logic [WORD_WIDTH-1:0] outData;
    logic                  outLast;

    modport master (output outValid, output outData, output outLast, input outReady);
    modport slave  (input outValid, input outData, input outLast, output outReady);
endinterface

// File: rtl/debug_trigger_controller_serializer.sv
// Streams the frozen snapshot out word by word; idx restarts at 0 on start.
import DebugTriggerTypes::*;

module debug_snapshot_serializer #(
    parameter int SNAP_WORDS = SNAP_WORDS_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [SNAP_WORDS*WORD_WIDTH-1:0] snap_in,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [WORD_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic                             done
);
    localparam int IDX_W = idx_width(SNAP_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SNAP_WORDS - 1);

    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign out_valid = valid_q;
    assign out_last  = valid_q && (idx_q == LAST_IDX);
    assign out_data  = valid_q ? snap_in[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH] : '0;
    assign done      = out_last && out_ready;

    // Next-state for the beat pointer; abort wins over start and handshakes.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        if (abort) begin
            valid_d = 1'b0;
        end else if (start) begin
            valid_d = 1'b1;
            idx_d   = '0;
        end else if (valid_q && out_ready) begin
            if (out_last) valid_d = 1'b0;
            else          idx_d   = idx_q + 1'b1;
        end
    end

    // Beat pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: rtl/debug_trigger_controller.sv
// Trigger-and-freeze sequencer: PC match with pass count and post window,
// then freezes the debug register and dumps it through the serializer.
//
// state  | meaning
// IDLE   | capturing, config writable, waiting for arm
// ARMED  | capturing, counting PC matches down to the trigger
// POST   | triggered, capturing the post-trigger window
// FROZEN | capture stopped, serializer being started
// DUMP   | streaming the frozen snapshot out
import DebugTriggerTypes::*;

module debug_trigger_controller #(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int PASS_WIDTH = PASS_WIDTH_DEF,
    parameter int POST_WIDTH = POST_WIDTH_DEF,
    parameter int SNAP_WORDS = SNAP_WORDS_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfgWrite,
    input  logic [PC_WIDTH-1:0]              cfgMatchPC,
    input  logic [PASS_WIDTH-1:0]            cfgPassCount,
    input  logic [POST_WIDTH-1:0]            cfgPostCount,
    input  logic                             arm,
    input  logic                             abort,
    input  logic                             commitValid,
    input  logic [PC_WIDTH-1:0]              committedPC,
    input  logic [SNAP_WORDS*WORD_WIDTH-1:0] snapIn,
    output logic                             captureEnable,
    output logic                             triggered,
    output logic                             busy,
    debug_trigger_controller_if.master       out_if
);
    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_ARMED  = ARMED;
    localparam logic [2:0] ST_POST   = POST;
    localparam logic [2:0] ST_FROZEN = FROZEN;
    localparam logic [2:0] ST_DUMP   = DUMP;

    logic [2:0]            state_q, state_d;
    logic [PC_WIDTH-1:0]   match_pc_q, match_pc_d;
    logic [PASS_WIDTH-1:0] pass_cfg_q, pass_cfg_d;
    logic [POST_WIDTH-1:0] post_cfg_q, post_cfg_d;
    logic [PASS_WIDTH-1:0] pass_left_q, pass_left_d;
    logic [POST_WIDTH-1:0] post_left_q, post_left_d;
    logic                  triggered_q, triggered_d;

    logic pc_match;
    logic ser_done;

    assign pc_match      = commitValid && (committedPC == match_pc_q);
    assign captureEnable = (state_q != ST_FROZEN) && (state_q != ST_DUMP);
    assign busy          = (state_q != ST_IDLE);
    assign triggered     = triggered_q;

    // Sequencer next-state, config latch and trigger counters.
    always_comb begin
        state_d     = state_q;
        match_pc_d  = match_pc_q;
        pass_cfg_d  = pass_cfg_q;
        post_cfg_d  = post_cfg_q;
        pass_left_d = pass_left_q;
        post_left_d = post_left_q;
        triggered_d = triggered_q;
        case (state_q)
            ST_IDLE: begin
                if (cfgWrite) begin
                    match_pc_d = cfgMatchPC;
                    pass_cfg_d = cfgPassCount;
                    post_cfg_d = cfgPostCount;
                end
                if (arm) begin
                    state_d     = ST_ARMED;
                    pass_left_d = cfgWrite ? cfgPassCount : pass_cfg_q;
                    post_left_d = cfgWrite ? cfgPostCount : post_cfg_q;
                    triggered_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (pc_match) begin
                    if (pass_left_q != '0) begin
                        pass_left_d = pass_left_q - 1'b1;
                    end else begin
                        triggered_d = 1'b1;
                        state_d     = (post_left_q != '0) ? ST_POST : ST_FROZEN;
                    end
                end
            end
            ST_POST: begin
                if (post_left_q != '0) post_left_d = post_left_q - 1'b1;
                if (post_left_q <= POST_WIDTH'(1)) state_d = ST_FROZEN;
            end
            ST_FROZEN: state_d = ST_DUMP;
            ST_DUMP:   if (ser_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // Sequencer, config and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            match_pc_q  <= '0;
            pass_cfg_q  <= '0;
            post_cfg_q  <= '0;
            pass_left_q <= '0;
            post_left_q <= '0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_pc_q  <= match_pc_d;
            pass_cfg_q  <= pass_cfg_d;
            post_cfg_q  <= post_cfg_d;
            pass_left_q <= pass_left_d;
            post_left_q <= post_left_d;
            triggered_q <= triggered_d;
        end
    end

    debug_snapshot_serializer #(
        .SNAP_WORDS (SNAP_WORDS),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .start     (state_q == ST_FROZEN),
        .abort     (abort),
        .snap_in   (snapIn),
        .out_ready (out_if.outReady),
        .out_valid (out_if.outValid),
        .out_data  (out_if.outData),
        .out_last  (out_if.outLast),
        .done      (ser_done)
    );
endmodule

// File: tb/tb_debug_trigger_controller.sv
// Directed bench for the debug trigger/freeze sequencer.
module tb_debug_trigger_controller;
    import DebugTriggerTypes::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfgWrite, arm, abort, commitValid;
    logic [31:0]  cfgMatchPC, committedPC;
    logic [7:0]   cfgPassCount, cfgPostCount;
    logic [511:0] snapIn;
    logic         captureEnable, triggered, busy;
    int           checks = 0;
    int           errors = 0;

    debug_trigger_controller_if #(.WORD_WIDTH(32)) out_if ();

    debug_trigger_controller dut (
        .clk           (clk),
        .rst           (rst),
        .cfgWrite      (cfgWrite),
        .cfgMatchPC    (cfgMatchPC),
        .cfgPassCount  (cfgPassCount),
        .cfgPostCount  (cfgPostCount),
        .arm           (arm),
        .abort         (abort),
        .commitValid   (commitValid),
        .committedPC   (committedPC),
        .snapIn        (snapIn),
        .captureEnable (captureEnable),
        .triggered     (triggered),
        .busy          (busy),
        .out_if        (out_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] word(input int i);
        return 32'hA500_0000 + i;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic v, input logic [31:0] pc);
        commitValid = v;
        committedPC = pc;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) snapIn[i*32 +: 32] = word(i);
        rst = 1'b0;
        cfgWrite = 0; arm = 0; abort = 0; commitValid = 0;
        cfgMatchPC = 0; committedPC = 0; cfgPassCount = 0; cfgPostCount = 0;
        out_if.outReady = 1'b0;
        #23;
        check("rst_ce", captureEnable, 1);
        check("rst_busy", busy, 0);
        check("rst_trig", triggered, 0);
        check("rst_valid", out_if.outValid, 0);
        check("rst_data", out_if.outData, 0);
        check("rst_last", out_if.outLast, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // pass 0, post 0; cfgWrite and arm together use the new values
        cfgWrite = 1; arm = 1; cfgMatchPC = 32'h1000; cfgPassCount = 0; cfgPostCount = 0;
        tick();
        cfgWrite = 0; arm = 0;
        check("t1_armed_busy", busy, 1);
        check("t1_armed_ce", captureEnable, 1);
        commit(1, 32'h1000); out_if.outReady = 1;
        tick();
        commit(0, 0);
        check("t1_frozen_ce", captureEnable, 0);
        check("t1_frozen_trig", triggered, 1);
        check("t1_frozen_valid", out_if.outValid, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            check("t1_dump_valid", out_if.outValid, 1);
            check("t1_dump_data", out_if.outData, word(i));
            check("t1_dump_last", out_if.outLast, (i == 15) ? 1 : 0);
            check("t1_dump_ce", captureEnable, 0);
            tick();
        end
        check("t1_idle_valid", out_if.outValid, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_ce", captureEnable, 1);
        check("t1_idle_trig_held", triggered, 1);

        // pass 2, post 3, with a stalled dump then abort at idx 5
        out_if.outReady = 0;
        cfgWrite = 1; cfgPassCount = 2; cfgPostCount = 3;
        tick();
        cfgWrite = 0; arm = 1;
        tick();
        arm = 0;
        check("t2_arm_trig_clr", triggered, 0);
        commit(1, 32'h1004); tick();
        check("t2_nomatch_trig", triggered, 0);
        commit(1, 32'h1000); tick();
        check("t2_match1_trig", triggered, 0);
        commit(0, 32'h1000); tick();
        check("t2_invalid_trig", triggered, 0);
        commit(1, 32'h1000); tick();
        check("t2_match2_trig", triggered, 0);
        check("t2_match2_busy", busy, 1);
        commit(1, 32'h1000); tick();
        check("t2_match3_trig", triggered, 1);
        check("t2_post1_ce", captureEnable, 1);
        tick();
        check("t2_post2_ce", captureEnable, 1);
        commit(0, 0);
        tick();
        check("t2_post3_ce", captureEnable, 1);
        tick();
        check("t2_frozen_ce", captureEnable, 0);
        check("t2_frozen_valid", out_if.outValid, 0);
        tick();
        check("t2_dump_valid", out_if.outValid, 1);
        check("t2_w0", out_if.outData, word(0));
        out_if.outReady = 1; tick();
        check("t2_w1", out_if.outData, word(1));
        out_if.outReady = 0; tick();
        check("t2_stall1", out_if.outData, word(1));
        check("t2_stall1_valid", out_if.outValid, 1);
        tick();
        check("t2_stall2", out_if.outData, word(1));
        check("t2_stall2_last", out_if.outLast, 0);
        out_if.outReady = 1; tick();
        check("t2_w2", out_if.outData, word(2));
        tick(); tick(); tick();
        check("t2_w5", out_if.outData, word(5));
        abort = 1; out_if.outReady = 0; tick();
        abort = 0;
        check("t2_abort_valid", out_if.outValid, 0);
        check("t2_abort_busy", busy, 0);
        check("t2_abort_ce", captureEnable, 1);

        // abort mid-POST, then re-arm with fresh counters
        arm = 1; tick(); arm = 0;
        commit(1, 32'h1000); tick(); tick(); tick();
        check("t3_post_trig", triggered, 1);
        commit(0, 0); tick();
        abort = 1; tick(); abort = 0;
        check("t3_abort_busy", busy, 0);
        check("t3_abort_ce", captureEnable, 1);
        check("t3_abort_valid", out_if.outValid, 0);
        arm = 1; abort = 1; tick(); abort = 0;
        check("t3_abort_over_arm", busy, 0);
        tick(); arm = 0;
        check("t3_rearm_busy", busy, 1);
        check("t3_rearm_trig", triggered, 0);
        commit(1, 32'h1000); tick();
        check("t3_m1", triggered, 0);
        tick();
        check("t3_m2", triggered, 0);
        tick();
        check("t3_m3", triggered, 1);
        commit(0, 0);
        tick(); tick();
        check("t3_post3_ce", captureEnable, 1);
        tick();
        check("t3_frozen_ce", captureEnable, 0);
        abort = 1; tick(); abort = 0;
        check("t3_abort_frozen_busy", busy, 0);
        tick();
        check("t3_no_dump", out_if.outValid, 0);

        // cfgWrite/arm during ARMED ignored; then async reset mid-dump
        cfgWrite = 1; arm = 1; cfgMatchPC = 32'h1000; cfgPassCount = 0; cfgPostCount = 0;
        tick();
        cfgMatchPC = 32'h2000; cfgPassCount = 5; cfgPostCount = 7;
        tick();
        cfgWrite = 0; arm = 0;
        check("t4_armed_busy", busy, 1);
        check("t4_armed_trig", triggered, 0);
        commit(1, 32'h2000); tick();
        check("t4_newpc_trig", triggered, 0);
        check("t4_newpc_ce", captureEnable, 1);
        commit(1, 32'h1000); tick();
        commit(0, 0);
        check("t4_oldpc_trig", triggered, 1);
        check("t4_oldpc_ce", captureEnable, 0);
        out_if.outReady = 1;
        tick(); tick(); tick(); tick();
        check("t4_w3", out_if.outData, word(3));
        #2 rst = 1'b0;
        #1;
        check("t4_arst_valid", out_if.outValid, 0);
        check("t4_arst_ce", captureEnable, 1);
        check("t4_arst_busy", busy, 0);
        check("t4_arst_trig", triggered, 0);
        check("t4_arst_data", out_if.outData, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("t4_post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
